rr_mux7_arbiter: RTL and testbench



---
 rtl/rr_mux7_arbiter.sv | 103 ++++++++++
 tb/tb_rr_mux7_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux7_arbiter.sv
// Round-robin arbiter for a 7-way shared datapath mux and its downstream resource.
// Grant and select are registered; a watchdog can force release of a stuck owner.
module rr_mux7_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] req,
    input  logic       done,
    output logic [6:0] gnt,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    localparam logic [CNT_W-1:0] C_LIMIT =
        (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_last;
    logic [6:0]       r_gnt;
    logic [2:0]       r_sel;
    logic             r_sel_valid;
    logic             r_timeout;

    logic       w_any;
    logic [2:0] w_pick;
    logic [3:0] w_sum;
    logic       w_owner;
    logic       w_wdog;
    logic       w_release;

    // Scan downward so the lowest offset from the last owner wins.
    always_comb begin
        w_any  = |req;
        w_pick = 3'd0;
        w_sum  = 4'd0;
        for (int off = 7; off >= 1; off--) begin
            w_sum = {1'b0, r_last} + 4'(off);
            if (w_sum >= 4'd7) begin
                w_sum = w_sum - 4'd7;
            end
            if (req[w_sum[2:0]]) begin
                w_pick = w_sum[2:0];
            end
        end
    end

    assign w_owner   = |(req & r_gnt);
    assign w_wdog    = (TIMEOUT != 0) && (r_cnt == C_LIMIT);
    assign w_release = done || !w_owner || w_wdog;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last      <= 3'd6;
            r_gnt       <= 7'd0;
            r_sel       <= 3'd0;
            r_sel_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_BUSY;
                        r_gnt       <= 7'd1 << w_pick;
                        r_sel       <= w_pick;
                        r_sel_valid <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                S_BUSY: begin
                    if (w_release) begin
                        r_state     <= S_IDLE;
                        r_gnt       <= 7'd0;
                        r_sel_valid <= 1'b0;
                        r_last      <= r_sel;
                        // Completion wins over a coincident watchdog expiry.
                        r_timeout   <= w_wdog && !done;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_mux7_arbiter.sv
// Bench for rr_mux7_arbiter: scoreboarded grant order, watchdog,
// owner withdrawal and asynchronous reset scenarios.
module tb_rr_mux7_arbiter;

    typedef struct packed {
        logic [6:0] gnt;
        logic [2:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] req;
    logic       done;

    logic [6:0] g_a, g_b, g_c;
    logic [2:0] s_a, s_b, s_c;
    logic       v_a, v_b, v_c;
    logic       t_a, t_b, t_c;

    logic [6:0] m_gnt;
    logic [2:0] m_sel;
    logic       m_sv;
    logic       m_to;
    int         dsel = 0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rr_mux7_arbiter u_dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .gnt(g_a), .sel(s_a), .sel_valid(v_a), .timeout(t_a)
    );

    rr_mux7_arbiter #(.TIMEOUT(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .gnt(g_b), .sel(s_b), .sel_valid(v_b), .timeout(t_b)
    );

    rr_mux7_arbiter #(.TIMEOUT(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .gnt(g_c), .sel(s_c), .sel_valid(v_c), .timeout(t_c)
    );

    always_comb begin
        m_gnt = g_a;
        m_sel = s_a;
        m_sv  = v_a;
        m_to  = t_a;
        if (dsel == 1) begin
            m_gnt = g_b;
            m_sel = s_b;
            m_sv  = v_b;
            m_to  = t_b;
        end else if (dsel == 2) begin
            m_gnt = g_c;
            m_sel = s_c;
            m_sv  = v_c;
            m_to  = t_c;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req    = 7'd0;
        done   = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_sv && n < 20);
    endtask

    task automatic test_reset();
        dsel   = 0;
        resetn = 1'b0;
        req    = 7'd0;
        done   = 1'b0;
        tick();
        checks++;
        if (m_gnt !== 7'd0 || m_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_gnt_sel: gnt=%b sel=%0d want gnt=0 sel=0",
                     m_gnt, m_sel);
        end
        checks++;
        if (m_sv !== 1'b0 || m_to !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_to: sel_valid=%b timeout=%b want 0 0",
                     m_sv, m_to);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_two_req();
        int   n;
        exp_t e;
        dsel = 0;
        do_reset();
        req = 7'b0000101;
        exp_q.push_back('{7'b0000001, 3'd0});
        exp_q.push_back('{7'b0000100, 3'd2});
        exp_q.push_back('{7'b0000001, 3'd0});
        for (int k = 0; k < 3; k++) begin
            wait_grant(n);
            checks++;
            if (n != 1) begin
                errors++;
                $display("FAIL two_req_latency[%0d]: cycles=%0d want 1", k, n);
            end
            e = exp_q.pop_front();
            checks++;
            if (m_gnt !== e.gnt || m_sel !== e.sel) begin
                errors++;
                $display("FAIL two_req_grant[%0d]: gnt=%b sel=%0d want gnt=%b sel=%0d",
                         k, m_gnt, m_sel, e.gnt, e.sel);
            end
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (m_sv !== 1'b0 || m_gnt !== 7'd0) begin
                errors++;
                $display("FAIL two_req_idle[%0d]: gnt=%b sel_valid=%b want 0 0",
                         k, m_gnt, m_sv);
            end
        end
    endtask

    task automatic test_all_req();
        int   n;
        exp_t e;
        dsel = 0;
        do_reset();
        req = 7'h7f;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{7'd1 << (i % 7), 3'(i % 7)});
        end
        for (int k = 0; k < 8; k++) begin
            wait_grant(n);
            e = exp_q.pop_front();
            checks++;
            if (n != 1 || m_gnt !== e.gnt || m_sel !== e.sel || m_sel === 3'd7) begin
                errors++;
                $display("FAIL all_req[%0d]: cycles=%0d gnt=%b sel=%0d want 1 %b %0d",
                         k, n, m_gnt, m_sel, e.gnt, e.sel);
            end
            tick();
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end
    endtask

    task automatic test_timeout();
        int   n;
        exp_t e;
        dsel = 1;
        do_reset();
        req = 7'b0001000;
        exp_q.push_back('{7'b0001000, 3'd3});
        exp_q.push_back('{7'b0001000, 3'd3});
        wait_grant(n);
        e = exp_q.pop_front();
        checks++;
        if (n != 1 || m_gnt !== e.gnt || m_sel !== e.sel) begin
            errors++;
            $display("FAIL wdog_grant: cycles=%0d gnt=%b sel=%0d want 1 %b %0d",
                     n, m_gnt, m_sel, e.gnt, e.sel);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m_gnt !== 7'b0001000 || m_to !== 1'b0) begin
                errors++;
                $display("FAIL wdog_hold[%0d]: gnt=%b timeout=%b want 0001000 0",
                         i, m_gnt, m_to);
            end
        end
        tick();
        checks++;
        if (m_gnt !== 7'd0 || m_to !== 1'b1 || m_sv !== 1'b0) begin
            errors++;
            $display("FAIL wdog_fire: gnt=%b timeout=%b sel_valid=%b want 0 1 0",
                     m_gnt, m_to, m_sv);
        end
        wait_grant(n);
        e = exp_q.pop_front();
        checks++;
        if (n != 1 || m_gnt !== e.gnt || m_sel !== e.sel || m_to !== 1'b0) begin
            errors++;
            $display("FAIL wdog_regrant: cycles=%0d gnt=%b sel=%0d to=%b want 1 %b %0d 0",
                     n, m_gnt, m_sel, m_to, e.gnt, e.sel);
        end
    endtask

    task automatic test_withdraw();
        int   n;
        exp_t e;
        dsel = 0;
        do_reset();
        req = 7'b0100000;
        exp_q.push_back('{7'b0100000, 3'd5});
        exp_q.push_back('{7'b0000010, 3'd1});
        wait_grant(n);
        e = exp_q.pop_front();
        checks++;
        if (n != 1 || m_gnt !== e.gnt || m_sel !== e.sel) begin
            errors++;
            $display("FAIL withdraw_grant5: cycles=%0d gnt=%b sel=%0d want 1 %b %0d",
                     n, m_gnt, m_sel, e.gnt, e.sel);
        end
        req = 7'b0100010;
        tick();
        checks++;
        if (m_gnt !== 7'b0100000) begin
            errors++;
            $display("FAIL withdraw_hold: gnt=%b want 0100000", m_gnt);
        end
        req = 7'b0000010;
        tick();
        checks++;
        if (m_gnt !== 7'd0 || m_sv !== 1'b0 || m_to !== 1'b0 || m_sel !== 3'd5) begin
            errors++;
            $display("FAIL withdraw_release: gnt=%b sv=%b to=%b sel=%0d want 0 0 0 5",
                     m_gnt, m_sv, m_to, m_sel);
        end
        wait_grant(n);
        e = exp_q.pop_front();
        checks++;
        if (n != 1 || m_gnt !== e.gnt || m_sel !== e.sel) begin
            errors++;
            $display("FAIL withdraw_grant1: cycles=%0d gnt=%b sel=%0d want 1 %b %0d",
                     n, m_gnt, m_sel, e.gnt, e.sel);
        end
    endtask

    task automatic test_done_wdog();
        int   n;
        exp_t e;
        dsel = 2;
        do_reset();
        req = 7'b0000100;
        exp_q.push_back('{7'b0000100, 3'd2});
        wait_grant(n);
        e = exp_q.pop_front();
        checks++;
        if (n != 1 || m_gnt !== e.gnt || m_sel !== e.sel) begin
            errors++;
            $display("FAIL done_wdog_grant: cycles=%0d gnt=%b sel=%0d want 1 %b %0d",
                     n, m_gnt, m_sel, e.gnt, e.sel);
        end
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (m_gnt !== 7'd0 || m_to !== 1'b0 || m_sv !== 1'b0) begin
            errors++;
            $display("FAIL done_wdog_release: gnt=%b timeout=%b sv=%b want 0 0 0",
                     m_gnt, m_to, m_sv);
        end
        req = 7'd0;
        tick();
        checks++;
        if (m_to !== 1'b0) begin
            errors++;
            $display("FAIL done_wdog_late_to: timeout=%b want 0", m_to);
        end
    endtask

    task automatic test_reset_mid_busy();
        int   n;
        exp_t e;
        dsel = 0;
        do_reset();
        req = 7'b0000100;
        exp_q.push_back('{7'b0000100, 3'd2});
        wait_grant(n);
        e = exp_q.pop_front();
        checks++;
        if (n != 1 || m_gnt !== e.gnt || m_sel !== e.sel) begin
            errors++;
            $display("FAIL rst_mid_pre: cycles=%0d gnt=%b sel=%0d want 1 %b %0d",
                     n, m_gnt, m_sel, e.gnt, e.sel);
        end
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 7'b0010000;
        exp_q.push_back('{7'b0010000, 3'd4});
        wait_grant(n);
        e = exp_q.pop_front();
        checks++;
        if (n != 1 || m_gnt !== e.gnt || m_sel !== e.sel) begin
            errors++;
            $display("FAIL rst_mid_grant4: cycles=%0d gnt=%b sel=%0d want 1 %b %0d",
                     n, m_gnt, m_sel, e.gnt, e.sel);
        end
        tick();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (m_gnt !== 7'd0 || m_sel !== 3'd0 || m_sv !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: gnt=%b sel=%0d sv=%b want 0 0 0",
                     m_gnt, m_sel, m_sv);
        end
        req = 7'b0010001;
        tick();
        resetn = 1'b1;
        exp_q.push_back('{7'b0000001, 3'd0});
        wait_grant(n);
        e = exp_q.pop_front();
        checks++;
        if (n != 1 || m_gnt !== e.gnt || m_sel !== e.sel) begin
            errors++;
            $display("FAIL rst_mid_ptr: cycles=%0d gnt=%b sel=%0d want 1 %b %0d",
                     n, m_gnt, m_sel, e.gnt, e.sel);
        end
    endtask

    initial begin
        resetn = 1'b0;
        req    = 7'd0;
        done   = 1'b0;
        test_reset();
        test_two_req();
        test_all_req();
        test_timeout();
        test_withdraw();
        test_done_wdog();
        test_reset_mid_busy();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
